// File: rtl/projectile_scheduler_pkg.sv
// Shared constants and types for the projectile scheduler: pool sizing,
// playfield geometry, movement speeds and the per-slot state record.
package projectile_scheduler_pkg;

   localparam int NUM_SLOTS  = 4;
   localparam int NUM_MONS   = 5;
   localparam int COORD_W    = 10;
   localparam int TANK_SPEED = 4;
   localparam int MONS_SPEED = 2;
   localparam int Y_TOP      = 35;
   localparam int Y_BOTTOM   = 515;
   localparam int X_LEFT     = 144;
   localparam int X_RIGHT    = 784;

   // Spawn offsets: tank shots appear above the tank, monster shots below the monster
   localparam int TANK_SPAWN_DY = 6;
   localparam int MONS_SPAWN_DY = 4;

   localparam int MONS_IDX_W = $clog2(NUM_MONS);

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic {
      SHOT_DOWN = 1'b0,
      SHOT_UP   = 1'b1
   } shot_dir_e;

   typedef struct packed {
      logic      valid;
      shot_dir_e dir;
      coord_t    x;
      coord_t    y;
   } slot_t;

endpackage

// File: rtl/projectile_scheduler_if.sv
// Request/grant and slot-state bundle between the game logic and the
// projectile scheduler. The requester side drives fire requests and hit
// clears; the scheduler drives slot state and grants.
interface projectile_scheduler_if;
   import projectile_scheduler_pkg::*;

   logic                          tick;
   logic                          tank_fire;
   logic [COORD_W-1:0]            tank_x;
   logic [COORD_W-1:0]            tank_y;
   logic [NUM_MONS-1:0]           mons_fire;
   logic [NUM_MONS*COORD_W-1:0]   mons_x;
   logic [NUM_MONS*COORD_W-1:0]   mons_y;
   logic [NUM_SLOTS-1:0]          hit_clear;
   logic [NUM_SLOTS-1:0]          slot_valid;
   logic [NUM_SLOTS-1:0]          slot_up;
   logic [NUM_SLOTS*COORD_W-1:0]  slot_x;
   logic [NUM_SLOTS*COORD_W-1:0]  slot_y;
   logic                          tank_grant;
   logic [NUM_MONS-1:0]           mons_grant;

   modport master (
      output tick, tank_fire, tank_x, tank_y, mons_fire, mons_x, mons_y, hit_clear,
      input  slot_valid, slot_up, slot_x, slot_y, tank_grant, mons_grant
   );

   modport slave (
      input  tick, tank_fire, tank_x, tank_y, mons_fire, mons_x, mons_y, hit_clear,
      output slot_valid, slot_up, slot_x, slot_y, tank_grant, mons_grant
   );

endinterface

// File: rtl/projectile_scheduler_rr_arbiter.sv
// Round-robin pick over N level requests. Purely combinational: the caller
// owns the pointer register and loads next_ptr only when the grant is taken.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] next_ptr
);

   logic [PW-1:0] idx;
   logic          found;

   // Scan from ptr upward with wrap; first requester wins, pointer moves past it
   always_comb begin
      gnt      = '0;
      next_ptr = ptr;
      found    = 1'b0;
      idx      = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            next_ptr = PW'((int'(idx) + 1) % N);
         end
      end
   end

endmodule

// File: rtl/projectile_scheduler.sv
// Shared projectile slot pool for the tank and the monster row. On each game
// tick live shots advance (or drop off the playfield) and at most one new
// shot is allocated into the lowest slot that was free before the edge.
// Collision hits free a slot on any edge and win over everything else.
module projectile_scheduler
   import projectile_scheduler_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   projectile_scheduler_if.slave   bus
);

   // Exit thresholds use one extra bit so y - speed / y + speed never wrap
   localparam logic [COORD_W:0] UP_LIMIT   = (COORD_W+1)'(Y_TOP + TANK_SPEED);
   localparam logic [COORD_W:0] DOWN_LIMIT = (COORD_W+1)'(Y_BOTTOM);
   localparam logic [COORD_W:0] MONS_STEP  = (COORD_W+1)'(MONS_SPEED);

   slot_t                 slot_q   [NUM_SLOTS];
   slot_t                 slot_nxt [NUM_SLOTS];
   slot_t                 spawn;
   logic [NUM_SLOTS-1:0]  up_live;
   logic [NUM_SLOTS-1:0]  free;
   logic [NUM_SLOTS-1:0]  taken;
   logic [NUM_SLOTS-1:0]  target;
   logic [NUM_SLOTS-1:0]  load;
   logic                  any_free;
   logic                  tank_sel;
   logic                  mons_any;
   logic [NUM_MONS-1:0]   arb_gnt;
   logic [NUM_MONS-1:0]   mons_sel;
   logic [MONS_IDX_W-1:0] rr_ptr;
   logic [MONS_IDX_W-1:0] rr_next;
   logic                  tank_grant_q;
   logic [NUM_MONS-1:0]   mons_grant_q;

   function automatic logic exits(slot_t s);
      logic [COORD_W:0] y_ext;
      y_ext = {1'b0, s.y};
      if (s.dir == SHOT_UP) return y_ext < UP_LIMIT;
      return (y_ext + MONS_STEP) > DOWN_LIMIT;
   endfunction

   function automatic coord_t step_y(slot_t s);
      if (s.dir == SHOT_UP) return s.y - coord_t'(TANK_SPEED);
      return s.y + coord_t'(MONS_SPEED);
   endfunction

   // Hit clear wins; otherwise a tick moves or retires a live shot, or loads a new one
   function automatic slot_t next_slot(slot_t cur, logic clr, logic stp, logic ld, slot_t sp);
      slot_t n;
      n = cur;
      if (clr) begin
         n.valid = 1'b0;
      end else if (stp && cur.valid) begin
         if (exits(cur)) n.valid = 1'b0;
         else            n.y     = step_y(cur);
      end else if (ld) begin
         n = sp;
      end
      return n;
   endfunction

   // Free-slot priority encoder and per-slot next state
   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      assign up_live[i] = slot_q[i].valid && (slot_q[i].dir == SHOT_UP);
      assign free[i]    = !slot_q[i].valid && !bus.hit_clear[i];
      if (i == 0) begin : g_first
         assign taken[i] = 1'b0;
      end else begin : g_rest
         assign taken[i] = taken[i-1] | free[i-1];
      end
      assign target[i]   = free[i] & ~taken[i];
      assign load[i]     = target[i] & (tank_sel | mons_any);
      assign slot_nxt[i] = next_slot(slot_q[i], bus.hit_clear[i], bus.tick, load[i], spawn);
   end

   assign any_free = |free;
   assign tank_sel = bus.tick && any_free && bus.tank_fire && !(|up_live);
   assign mons_sel = (bus.tick && any_free && !tank_sel) ? arb_gnt : '0;
   assign mons_any = |mons_sel;

   rr_arbiter #(.N(NUM_MONS), .PW(MONS_IDX_W)) u_rr (
      .req      (bus.mons_fire),
      .ptr      (rr_ptr),
      .gnt      (arb_gnt),
      .next_ptr (rr_next)
   );

   // Spawn record for whichever requester won this tick
   always_comb begin
      spawn.valid = 1'b1;
      spawn.dir   = SHOT_UP;
      spawn.x     = bus.tank_x;
      spawn.y     = bus.tank_y - coord_t'(TANK_SPAWN_DY);
      if (!tank_sel) begin
         for (int m = 0; m < NUM_MONS; m++) begin
            if (mons_sel[m]) begin
               spawn.dir = SHOT_DOWN;
               spawn.x   = bus.mons_x[m*COORD_W +: COORD_W];
               spawn.y   = bus.mons_y[m*COORD_W +: COORD_W] + coord_t'(MONS_SPAWN_DY);
            end
         end
      end
   end

   // Slot pool, grant pulses and round-robin pointer; reset wipes everything at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
         tank_grant_q <= 1'b0;
         mons_grant_q <= '0;
         rr_ptr       <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_nxt[i];
         tank_grant_q <= tank_sel;
         mons_grant_q <= mons_sel;
         if (mons_any) rr_ptr <= rr_next;
      end
   end

   // Flatten registered slot state onto the packed output buses
   always_comb begin
      bus.slot_valid = '0;
      bus.slot_up    = '0;
      bus.slot_x     = '0;
      bus.slot_y     = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         bus.slot_valid[i]                 = slot_q[i].valid;
         bus.slot_up[i]                    = (slot_q[i].dir == SHOT_UP);
         bus.slot_x[i*COORD_W +: COORD_W]  = slot_q[i].x;
         bus.slot_y[i*COORD_W +: COORD_W]  = slot_q[i].y;
      end
   end

   assign bus.tank_grant = tank_grant_q;
   assign bus.mons_grant = mons_grant_q;

endmodule
